alu_cmd_scheduler: RTL and testbench

ALU_CMD_SCHEDULER -- requirements
Module: alu_cmd_scheduler

---
 rtl/alu_cmd_scheduler_if.sv | 44 ++++
 rtl/alu_cmd_scheduler.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_scheduler_if.sv
// Host command, ALU issue/return and result signals of alu_cmd_scheduler.
// slave: the scheduler's view. master: the host-plus-ALU environment's view.
interface alu_cmd_scheduler_if #(
    parameter int INST_W = 4,
    parameter int DATA_W = 16
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [INST_W-1:0] i_cmd_inst;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;

    logic              o_alu_valid;
    logic [INST_W-1:0] o_alu_inst;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic              i_alu_busy;
    logic              i_alu_out_valid;
    logic [DATA_W-1:0] i_alu_data;

    logic              o_res_valid;
    logic              i_res_ready;
    logic [DATA_W-1:0] o_res_data;
    logic [INST_W-1:0] o_res_inst;
    logic              o_res_err;

    modport slave (
        input  i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b,
        output o_cmd_ready,
        output o_alu_valid, o_alu_inst, o_alu_a, o_alu_b,
        input  i_alu_busy, i_alu_out_valid, i_alu_data,
        output o_res_valid, o_res_data, o_res_inst, o_res_err,
        input  i_res_ready
    );

    modport master (
        output i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b,
        input  o_cmd_ready,
        input  o_alu_valid, o_alu_inst, o_alu_a, o_alu_b,
        output i_alu_busy, i_alu_out_valid, i_alu_data,
        input  o_res_valid, o_res_data, o_res_inst, o_res_err,
        output i_res_ready
    );
endinterface

// File: rtl/alu_cmd_scheduler.sv
// Command FIFO feeding a single-outstanding ALU through IDLE/ISSUE/WAIT/HOLD.
// Define ALU_SCHED_TIMEOUT_EN to abort a WAIT after 15 cycles with o_res_err=1.
module alu_cmd_scheduler #(
    parameter int INST_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_cmd_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    state_e      state;
    state_e      state_nxt;
    logic        load_res;
    logic        tmo_hit;
    cmd_t        issue_q;

    logic [DATA_W-1:0] res_data;
    logic [INST_W-1:0] res_inst;

    // The extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.o_cmd_ready = i_rst_n && !full;
    assign push            = bus.i_cmd_valid && bus.o_cmd_ready;

    // NOTE: the storage array is deliberately not reset; the pointers alone decide
    // which entries are live, so clearing the data would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{inst: bus.i_cmd_inst, a: bus.i_cmd_a, b: bus.i_cmd_b};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    // Counts WAIT cycles from 0; reaching 14 means this is the 15th silent cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
        end
    end

    assign tmo_hit = (state == S_WAIT) && !bus.i_alu_out_valid && (tmo_cnt == 4'd14);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_res  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !bus.i_alu_busy) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.i_alu_out_valid || tmo_hit) begin
                    load_res  = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.i_res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The issue register keeps driving the last command's fields outside ISSUE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issue_q <= '0;
        end else if (pop) begin
            issue_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_data <= '0;
            res_inst <= '0;
        end else if (load_res) begin
            res_data <= tmo_hit ? '0 : bus.i_alu_data;
            res_inst <= issue_q.inst;
        end
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    logic res_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_err <= 1'b0;
        end else if (load_res) begin
            res_err <= tmo_hit;
        end
    end

    assign bus.o_res_err = res_err;
`else
    assign bus.o_res_err = 1'b0;
`endif

    assign bus.o_alu_valid = (state == S_ISSUE);
    assign bus.o_alu_inst  = issue_q.inst;
    assign bus.o_alu_a     = issue_q.a;
    assign bus.o_alu_b     = issue_q.b;

    assign bus.o_res_valid = (state == S_HOLD);
    assign bus.o_res_data  = res_data;
    assign bus.o_res_inst  = res_inst;

    a_alu_valid_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.o_alu_valid |=> !bus.o_alu_valid);

    a_res_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.o_res_valid && !bus.i_res_ready) |=>
            (bus.o_res_valid && $stable(bus.o_res_data) && $stable(bus.o_res_inst)));
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Randomized and directed bench for alu_cmd_scheduler with a 2-cycle ALU responder
// and an in-order queue model of accepted commands and expected results.
module tb_alu_cmd_scheduler;
    localparam int INST_W = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_s;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] data;
        logic              err;
    } res_s;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_scheduler_if #(.INST_W(INST_W), .DATA_W(DATA_W)) bus ();

    alu_cmd_scheduler #(.INST_W(INST_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   exp_lat = 3;
    int   last_issue_cyc = 0;
    bit   alu_mute = 1'b0;
    cmd_s issue_q [$];
    res_s res_q [$];
    int   issue_cycles [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_ref(input logic [INST_W-1:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // ALU stand-in: answers 2 cycles after a sampled o_alu_valid, garbage data otherwise.
    initial begin : alu_model
        logic [DATA_W-1:0] d;
        bus.i_alu_out_valid = 1'b0;
        bus.i_alu_data      = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_alu_valid && !alu_mute) begin
                d = alu_ref(bus.o_alu_inst, bus.o_alu_a, bus.o_alu_b);
                @(posedge clk);
                @(posedge clk);
                #1;
                bus.i_alu_out_valid = 1'b1;
                bus.i_alu_data      = d;
                @(posedge clk);
                #1;
                bus.i_alu_out_valid = 1'b0;
                bus.i_alu_data      = DATA_W'($urandom);
            end
        end
    end

    // Scoreboard: accepted commands must issue in order, results must return in order.
    initial begin : monitor
        bit   prev_alu_valid = 1'b0;
        bit   prev_busy      = 1'b0;
        bit   prev_res_valid = 1'b0;
        cmd_s c;
        res_s r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.i_cmd_valid && bus.o_cmd_ready)
                    issue_q.push_back('{inst: bus.i_cmd_inst, a: bus.i_cmd_a, b: bus.i_cmd_b});
                if (bus.o_alu_valid) begin
                    check("alu_single_cycle", prev_alu_valid, 1'b0);
                    check("issue_while_busy", prev_busy, 1'b0);
                    check("issue_has_cmd", issue_q.size() != 0, 1'b1);
                    if (issue_q.size() != 0) begin
                        c = issue_q.pop_front();
                        check("alu_inst", bus.o_alu_inst, c.inst);
                        check("alu_a", bus.o_alu_a, c.a);
                        check("alu_b", bus.o_alu_b, c.b);
                        if (alu_mute) res_q.push_back('{inst: c.inst, data: '0, err: 1'b1});
                        else res_q.push_back('{inst: c.inst, data: alu_ref(c.inst, c.a, c.b), err: 1'b0});
                    end
                    last_issue_cyc = cyc;
                    issue_cycles.push_back(cyc);
                end
                if (bus.o_res_valid && !prev_res_valid)
                    check("res_latency", cyc - last_issue_cyc, exp_lat);
                if (bus.o_res_valid && bus.i_res_ready) begin
                    check("res_expected", res_q.size() != 0, 1'b1);
                    if (res_q.size() != 0) begin
                        r = res_q.pop_front();
                        check("res_data", bus.o_res_data, r.data);
                        check("res_inst", bus.o_res_inst, r.inst);
                        check("res_err", bus.o_res_err, r.err);
                    end
                end
            end
            prev_alu_valid = bus.o_alu_valid;
            prev_busy      = bus.i_alu_busy;
            prev_res_valid = bus.o_res_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_accept(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.o_cmd_ready) begin
                @(posedge clk);
                #1;
                bus.i_cmd_valid = 1'b0;
                return;
            end
        end
        check("cmd_accept_timeout", bus.o_cmd_ready, 1'b1);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic drive_cmd(input logic [INST_W-1:0] inst, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b);
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_inst  = inst;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
    endtask

    task automatic push_cmd(input logic [INST_W-1:0] inst, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b);
        drive_cmd(inst, a, b);
        wait_accept(64);
    endtask

    task automatic push_rand();
        push_cmd(INST_W'($urandom_range(0, 15)), DATA_W'($urandom), DATA_W'($urandom));
    endtask

    task automatic wait_res(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.o_res_valid) return;
        end
        check("res_wait_timeout", bus.o_res_valid, 1'b1);
    endtask

    task automatic wait_issue(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.o_alu_valid) return;
        end
        check("issue_wait_timeout", bus.o_alu_valid, 1'b1);
    endtask

    task automatic wait_drain(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (issue_q.size() == 0 && res_q.size() == 0) return;
        end
        check("drain_issue_q", issue_q.size(), 0);
        check("drain_res_q", res_q.size(), 0);
    endtask

    task automatic at_next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [DATA_W-1:0] held;
        int   accepted;
        bit   took;

        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_inst  = '0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_alu_busy  = 1'b0;
        bus.i_res_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.o_cmd_ready, 1'b0);
        check("rst_alu_valid", bus.o_alu_valid, 1'b0);
        check("rst_res_valid", bus.o_res_valid, 1'b0);
        check("rst_res_err", bus.o_res_err, 1'b0);
        check("rst_alu_inst", bus.o_alu_inst, '0);
        check("rst_alu_a", bus.o_alu_a, '0);
        check("rst_alu_b", bus.o_alu_b, '0);
        check("rst_res_data", bus.o_res_data, '0);
        check("rst_res_inst", bus.o_res_inst, '0);
        #3 rst_n = 1'b1;
        at_next_edge();
        check("ready_after_reset", bus.o_cmd_ready, 1'b1);

        // ADD 0x0400 + 0x0400
        bus.i_res_ready = 1'b1;
        push_cmd(4'd0, 16'h0400, 16'h0400);
        wait_res(20);
        check("add_data", bus.o_res_data, 16'h0800);
        check("add_inst", bus.o_res_inst, 4'd0);
        wait_drain(20);

        // Throughput with result ready held high: one issue every 5 cycles
        at_next_edge();
        bus.i_alu_busy = 1'b1;
        repeat (4) push_rand();
        issue_cycles.delete();
        at_next_edge();
        bus.i_alu_busy = 1'b0;
        wait_drain(60);
        check("tput_issues", issue_cycles.size(), 4);
        for (int i = 1; i < issue_cycles.size(); i++)
            check("tput_spacing", issue_cycles[i] - issue_cycles[i-1], 5);

        // Fill the FIFO with issue blocked, 5th waits; then hold a result in HOLD
        at_next_edge();
        bus.i_res_ready = 1'b0;
        bus.i_alu_busy  = 1'b1;
        repeat (4) push_rand();
        @(negedge clk);
        check("full_ready_low", bus.o_cmd_ready, 1'b0);
        drive_cmd(INST_W'($urandom_range(0, 15)), DATA_W'($urandom), DATA_W'($urandom));
        repeat (3) begin
            @(negedge clk);
            check("full_5th_blocked", bus.o_cmd_ready, 1'b0);
        end
        at_next_edge();
        bus.i_alu_busy = 1'b0;
        wait_accept(10);
        wait_res(20);
        held = bus.o_res_data;
        repeat (8) begin
            @(negedge clk);
            check("hold_valid", bus.o_res_valid, 1'b1);
            check("hold_data", bus.o_res_data, held);
            check("hold_no_issue", bus.o_alu_valid, 1'b0);
        end
        at_next_edge();
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        check("ready_plus0", bus.o_alu_valid, 1'b0);
        @(negedge clk);
        check("ready_plus1", bus.o_alu_valid, 1'b0);
        @(negedge clk);
        check("ready_plus2_issue", bus.o_alu_valid, 1'b1);
        wait_drain(80);

        // Busy held for 10 cycles with a queued command
        at_next_edge();
        bus.i_alu_busy = 1'b1;
        push_rand();
        repeat (10) begin
            @(negedge clk);
            check("busy_no_issue", bus.o_alu_valid, 1'b0);
        end
        at_next_edge();
        bus.i_alu_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_same", bus.o_alu_valid, 1'b0);
        @(negedge clk);
        check("busy_fall_issue", bus.o_alu_valid, 1'b1);
        wait_drain(20);

        // Reset during WAIT with one more command queued
        at_next_edge();
        bus.i_alu_busy = 1'b1;
        repeat (2) push_rand();
        at_next_edge();
        bus.i_alu_busy = 1'b0;
        wait_issue(10);
        at_next_edge();
        rst_n = 1'b0;
        #1;
        check("wrst_cmd_ready", bus.o_cmd_ready, 1'b0);
        check("wrst_alu_valid", bus.o_alu_valid, 1'b0);
        check("wrst_res_valid", bus.o_res_valid, 1'b0);
        check("wrst_alu_inst", bus.o_alu_inst, '0);
        check("wrst_alu_a", bus.o_alu_a, '0);
        check("wrst_alu_b", bus.o_alu_b, '0);
        check("wrst_res_data", bus.o_res_data, '0);
        issue_q.delete();
        res_q.delete();
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_quiet", {bus.o_alu_valid, bus.o_res_valid}, 2'b00);
        end
        check("post_rst_ready", bus.o_cmd_ready, 1'b1);

        // ALU that never answers
        at_next_edge();
        alu_mute = 1'b1;
`ifdef ALU_SCHED_TIMEOUT_EN
        exp_lat = 16;
        push_rand();
        wait_res(40);
        check("tmo_err", bus.o_res_err, 1'b1);
        check("tmo_data", bus.o_res_data, '0);
        wait_drain(10);
        at_next_edge();
        exp_lat  = 3;
        alu_mute = 1'b0;
`else
        push_rand();
        wait_issue(10);
        repeat (30) begin
            @(negedge clk);
            check("wait_forever", bus.o_res_valid, 1'b0);
        end
        check("err_tied_low", bus.o_res_err, 1'b0);
        at_next_edge();
        rst_n = 1'b0;
        issue_q.delete();
        res_q.delete();
        #3 rst_n = 1'b1;
        alu_mute = 1'b0;
`endif

        // Randomized traffic with random busy and result back-pressure
        accepted = 0;
        took     = 1'b0;
        for (int i = 0; i < 6000 && accepted < 150; i++) begin
            at_next_edge();
            if (!bus.i_cmd_valid || took) begin
                bus.i_cmd_valid = 1'($urandom_range(0, 1));
                bus.i_cmd_inst  = INST_W'($urandom_range(0, 15));
                bus.i_cmd_a     = DATA_W'($urandom);
                bus.i_cmd_b     = DATA_W'($urandom);
            end
            bus.i_alu_busy  = ($urandom_range(0, 3) == 0);
            bus.i_res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = bus.i_cmd_valid && bus.o_cmd_ready;
            if (took) accepted++;
        end
        at_next_edge();
        bus.i_cmd_valid = 1'b0;
        bus.i_alu_busy  = 1'b0;
        bus.i_res_ready = 1'b1;
        check("rand_accepted", accepted, 150);
        wait_drain(200);
        repeat (3) @(negedge clk);
        check("final_idle", {bus.o_cmd_ready, bus.o_alu_valid, bus.o_res_valid}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
